store_wdata_packer: RTL and testbench

- Downstream stage of the LSU store buffer: consumes 128-bit SRAM lines read back for a store burst and serializes them into 64-bit AXI write-data beats.
- Generates wstrb and wlast, absorbs wrdy backpressure with a registered output, and reports burst completion.
- Sits between the store buffer's SRAM-readback path and the AXI W channel.

---
 rtl/store_wdata_packer.sv | 202 ++++++++++++++++++++
 tb/tb_store_wdata_packer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_wdata_packer.sv
// store_wdata_packer
//   Serializes 128-bit SRAM store-buffer lines into 64-bit AXI W beats with
//   wstrb/wlast generation, a registered wrdy-tolerant output stage and a
//   burst completion pulse.
//   Optional: define STORE_WDATA_PACKER_PERF_CNT_EN to add the wstall_cnt
//   port, a saturating count of cycles with axi_wvld & ~axi_wrdy.
module store_wdata_packer #(
    parameter int LINE_WIDTH  = 128,
    parameter int WDATA_WIDTH = 64,
    parameter int WSTRB_WIDTH = WDATA_WIDTH / 8,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_vld,
    output logic                   cmd_rdy,
    input  logic [7:0]             cmd_awlen,
    input  logic [2:0]             cmd_awsize,
    input  logic                   line_vld,
    output logic                   line_rdy,
    input  logic [ADDR_WIDTH-1:0]  line_addr,
    input  logic [LINE_WIDTH-1:0]  line_data,
    output logic                   axi_wvld,
    input  logic                   axi_wrdy,
    output logic [WDATA_WIDTH-1:0] axi_wdata,
    output logic [WSTRB_WIDTH-1:0] axi_wstrb,
    output logic                   axi_wlast,
    output logic [ADDR_WIDTH-1:0]  axi_oram_addr,
`ifdef STORE_WDATA_PACKER_PERF_CNT_EN
    output logic [15:0]            wstall_cnt,
`endif
    output logic                   burst_done
);

    localparam int LINE_BYTES = LINE_WIDTH / 8;
    localparam int IDX_W      = $clog2(LINE_BYTES);
    localparam int OFF_W      = $clog2(LINE_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [7:0]              r_awlen;
    logic [1:0]              r_size;
    logic [8:0]              r_beat_cnt;
    logic [IDX_W-1:0]        r_elem_idx;

    logic                    r_line_full;
    logic [LINE_WIDTH-1:0]   r_line_data;
    logic [ADDR_WIDTH-1:0]   r_line_addr;

    logic                    r_wvld;
    logic [WDATA_WIDTH-1:0]  r_wdata;
    logic [WSTRB_WIDTH-1:0]  r_wstrb;
    logic                    r_wlast;
    logic [ADDR_WIDTH-1:0]   r_oram_addr;

    logic                    w_cmd_acc;
    logic [1:0]              w_size_clamped;
    logic [IDX_W:0]          w_elems;
    logic                    w_last_elem;
    logic                    w_final_beat;
    logic                    w_load;
    logic                    w_line_acc;
    logic                    w_beat_hs;
    logic [OFF_W-1:0]        w_bit_off;
    logic [WDATA_WIDTH-1:0]  w_elem_raw;
    logic [WSTRB_WIDTH-1:0]  w_strb;
    logic [WDATA_WIDTH-1:0]  w_wdata;

    // Handshake and element-selection decode.
    assign cmd_rdy        = (r_state == S_IDLE);
    assign w_cmd_acc      = cmd_vld & cmd_rdy;
    assign w_size_clamped = (cmd_awsize > 3'd3) ? 2'd3 : cmd_awsize[1:0];
    assign w_elems        = (IDX_W + 1)'(LINE_BYTES) >> r_size;
    assign w_last_elem    = ({1'b0, r_elem_idx} == (w_elems - (IDX_W + 1)'(1)));
    assign w_final_beat   = (r_beat_cnt == {1'b0, r_awlen});
    assign w_load         = r_line_full & (r_state == S_BURST) & (~r_wvld | axi_wrdy);
    assign line_rdy       = (r_state == S_BURST) & (~r_line_full | (w_load & w_last_elem));
    assign w_line_acc     = line_vld & line_rdy;
    assign w_beat_hs      = r_wvld & axi_wrdy;
    assign burst_done     = (r_state == S_DRAIN) & w_beat_hs & r_wlast;

    assign w_bit_off  = (OFF_W'(r_elem_idx) << r_size) << 3;
    assign w_elem_raw = WDATA_WIDTH'(r_line_data >> w_bit_off);
    assign w_strb     = WSTRB_WIDTH'((32'd1 << (32'd1 << r_size)) - 32'd1);

    // Right-justify the selected element and zero the bytes above it.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_wdata = '0;
        for (int i = 0; i < WSTRB_WIDTH; i++) begin
            if (w_strb[i]) begin
                w_wdata[i*8 +: 8] = w_elem_raw[i*8 +: 8];
            end
        end
    end

    // Next-state logic for the burst sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_cmd_acc)             w_state_nxt = S_BURST;
            S_BURST: if (w_load & w_final_beat) w_state_nxt = S_DRAIN;
            S_DRAIN: if (burst_done)            w_state_nxt = S_IDLE;
            default:                            w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Burst parameters and beat/element position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_awlen    <= '0;
            r_size     <= '0;
            r_beat_cnt <= '0;
            r_elem_idx <= '0;
        end else if (w_cmd_acc) begin
            r_awlen    <= cmd_awlen;
            r_size     <= w_size_clamped;
            r_beat_cnt <= '0;
            r_elem_idx <= '0;
        end else if (w_load) begin
            r_beat_cnt <= r_beat_cnt + 9'd1;
            r_elem_idx <= (w_last_elem | w_final_beat) ? '0 : r_elem_idx + IDX_W'(1);
        end
    end

    // Single-entry line register; the final beat of a burst always empties it,
    // discarding unread elements and any line offered alongside that beat.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the payload is reset too, so a burst abandoned by reset leaves no stale line data behind.
        if (!rst_n) begin
            r_line_full <= 1'b0;
            r_line_data <= '0;
            r_line_addr <= '0;
        end else if (w_load & w_final_beat) begin
            r_line_full <= 1'b0;
        end else if (w_line_acc) begin
            r_line_full <= 1'b1;
            r_line_data <= line_data;
            r_line_addr <= line_addr;
        end else if (w_load & w_last_elem) begin
            r_line_full <= 1'b0;
        end
    end

    // AXI W output register: load a beat when empty or draining, hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wvld      <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_wlast     <= 1'b0;
            r_oram_addr <= '0;
        end else if (w_load) begin
            r_wvld      <= 1'b1;
            r_wdata     <= w_wdata;
            r_wstrb     <= w_strb;
            r_wlast     <= w_final_beat;
            r_oram_addr <= r_line_addr;
        end else if (w_beat_hs) begin
            r_wvld      <= 1'b0;
            r_wlast     <= 1'b0;
        end
    end

    assign axi_wvld      = r_wvld;
    assign axi_wdata     = r_wdata;
    assign axi_wstrb     = r_wstrb;
    assign axi_wlast     = r_wlast;
    assign axi_oram_addr = r_oram_addr;

`ifdef STORE_WDATA_PACKER_PERF_CNT_EN
    logic [15:0] r_wstall_cnt;

    // Saturating count of stalled write-beat cycles, restarted per burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstall_cnt <= '0;
        end else if (w_cmd_acc) begin
            r_wstall_cnt <= '0;
        end else if (r_wvld & ~axi_wrdy & (r_wstall_cnt != 16'hFFFF)) begin
            r_wstall_cnt <= r_wstall_cnt + 16'd1;
        end
    end

    assign wstall_cnt = r_wstall_cnt;
`endif

endmodule

// File: tb/tb_store_wdata_packer.sv
// tb_store_wdata_packer
//   Randomized and directed bursts checked against a line/element reference
//   model built from the packing rules (beat k -> line k/epl, element k%epl).
module tb_store_wdata_packer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_vld;
    logic         cmd_rdy;
    logic [7:0]   cmd_awlen;
    logic [2:0]   cmd_awsize;
    logic         line_vld;
    logic         line_rdy;
    logic [7:0]   line_addr;
    logic [127:0] line_data;
    logic         axi_wvld;
    logic         axi_wrdy;
    logic [63:0]  axi_wdata;
    logic [7:0]   axi_wstrb;
    logic         axi_wlast;
    logic [7:0]   axi_oram_addr;
    logic         burst_done;
`ifdef STORE_WDATA_PACKER_PERF_CNT_EN
    logic [15:0]  wstall_cnt;
`endif

    always #5 clk = ~clk;

    store_wdata_packer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_vld       (cmd_vld),
        .cmd_rdy       (cmd_rdy),
        .cmd_awlen     (cmd_awlen),
        .cmd_awsize    (cmd_awsize),
        .line_vld      (line_vld),
        .line_rdy      (line_rdy),
        .line_addr     (line_addr),
        .line_data     (line_data),
        .axi_wvld      (axi_wvld),
        .axi_wrdy      (axi_wrdy),
        .axi_wdata     (axi_wdata),
        .axi_wstrb     (axi_wstrb),
        .axi_wlast     (axi_wlast),
        .axi_oram_addr (axi_oram_addr),
`ifdef STORE_WDATA_PACKER_PERF_CNT_EN
        .wstall_cnt    (wstall_cnt),
`endif
        .burst_done    (burst_done)
    );

    typedef struct {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
        logic [7:0]  addr;
    } beat_t;

    typedef struct {
        logic [127:0] data;
        logic [7:0]   addr;
    } line_t;

    beat_t exp_q[$];
    line_t line_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // mode 0: lines always offered, wrdy=1; mode 1: random line_vld/wrdy;
    // mode 2: wrdy low for the first 5 cycles beat 0 is presented.
    // abort_after > 0 asserts reset once that many beats have completed.
    task automatic run_burst(input int awlen, input int size_raw, input int mode,
                             input bit ramp, input bit keep_vld, input int abort_after);
        int    size, nbytes, epl, nbeats, nlines;
        int    hs, cyc, stalls, stall5, last_hs_cyc;
        bit    prev_stall, done, line_acc;
        beat_t prev;
        line_t lines[$];

        size   = (size_raw > 3) ? 3 : size_raw;
        nbytes = 1 << size;
        epl    = 16 / nbytes;
        nbeats = awlen + 1;
        nlines = (nbeats + epl - 1) / epl;

        for (int li = 0; li < nlines; li++) begin
            line_t l;
            for (int b = 0; b < 16; b++)
                l.data[8*b +: 8] = ramp ? 8'(li * 16 + b) : 8'($urandom);
            l.addr = 8'($urandom);
            lines.push_back(l);
            line_q.push_back(l);
        end
        for (int k = 0; k < nbeats; k++) begin
            beat_t      bt;
            logic [8:0] s;
            int         li, e;
            li      = k / epl;
            e       = k % epl;
            bt.data = '0;
            for (int b = 0; b < nbytes; b++)
                bt.data[8*b +: 8] = lines[li].data[8*(e*nbytes + b) +: 8];
            s       = (9'd1 << nbytes) - 9'd1;
            bt.strb = s[7:0];
            bt.last = (k == awlen);
            bt.addr = lines[li].addr;
            exp_q.push_back(bt);
        end

        @(negedge clk);
        cmd_vld    = 1'b1;
        cmd_awlen  = 8'(awlen);
        cmd_awsize = 3'(size_raw);
        #4;
        check("cmd_rdy_idle", cmd_rdy, 1);
        @(posedge clk);

        hs = 0; cyc = 0; stalls = 0; stall5 = 0; last_hs_cyc = -1;
        prev_stall = 1'b0; done = 1'b0;
        prev = '{default: '0};
        while (!done && cyc < 4000) begin
            @(negedge clk);
            if (!keep_vld) cmd_vld = 1'b0;
            if (line_q.size() > 0 && (mode != 1 || $urandom_range(0, 3) != 0)) begin
                line_vld  = 1'b1;
                line_data = line_q[0].data;
                line_addr = line_q[0].addr;
            end else begin
                line_vld  = 1'b0;
                line_data = '0;
                line_addr = '0;
            end
            case (mode)
                1: axi_wrdy = ($urandom_range(0, 9) < 7);
                2: begin
                    if (axi_wvld && hs == 0 && stall5 < 5) begin
                        axi_wrdy = 1'b0;
                        stall5++;
                    end else begin
                        axi_wrdy = 1'b1;
                    end
                end
                default: axi_wrdy = 1'b1;
            endcase
            #4;
            check("cmd_rdy_busy", cmd_rdy, 0);
            if (prev_stall) begin
                check("hold_vld",  axi_wvld,      1);
                check("hold_data", axi_wdata,     prev.data);
                check("hold_strb", axi_wstrb,     prev.strb);
                check("hold_last", axi_wlast,     prev.last);
                check("hold_addr", axi_oram_addr, prev.addr);
            end
            if (hs + int'(axi_wvld) == nbeats)
                check("line_rdy_drain", line_rdy, 0);
            line_acc = line_vld & line_rdy;
            if (axi_wvld && axi_wrdy) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("wdata",      axi_wdata,     e.data);
                    check("wstrb",      axi_wstrb,     e.strb);
                    check("wlast",      axi_wlast,     e.last);
                    check("oram_addr",  axi_oram_addr, e.addr);
                    check("burst_done", burst_done,    e.last);
                    if (mode == 0 && last_hs_cyc >= 0)
                        check("b2b_gap", 64'(cyc - last_hs_cyc), 1);
                    if (e.last) done = 1'b1;
                end
                last_hs_cyc = cyc;
                hs++;
            end else begin
                check("no_done", burst_done, 0);
            end
            prev_stall = axi_wvld & ~axi_wrdy;
            if (prev_stall) stalls++;
            prev.data = axi_wdata;
            prev.strb = axi_wstrb;
            prev.last = axi_wlast;
            prev.addr = axi_oram_addr;
            @(posedge clk);
            if (line_acc) void'(line_q.pop_front());
            cyc++;

            if (abort_after > 0 && hs == abort_after) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_wvld",   axi_wvld,      0);
                check("rst_wdata",  axi_wdata,     0);
                check("rst_wstrb",  axi_wstrb,     0);
                check("rst_wlast",  axi_wlast,     0);
                check("rst_addr",   axi_oram_addr, 0);
                check("rst_done",   burst_done,    0);
                check("rst_linerdy", line_rdy,     0);
                check("rst_cmdrdy", cmd_rdy,       1);
                @(negedge clk);
                line_vld = 1'b0;
                cmd_vld  = 1'b0;
                axi_wrdy = 1'b1;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                exp_q.delete();
                line_q.delete();
                repeat (4) begin
                    @(negedge clk);
                    #4;
                    check("post_rst_done",   burst_done, 0);
                    check("post_rst_cmdrdy", cmd_rdy,    1);
                    check("post_rst_wvld",   axi_wvld,   0);
                end
                return;
            end
        end

        if (!done) check("timeout", 0, 1);
        #1;
        check("exp_empty",  64'(exp_q.size()),  0);
        check("line_empty", 64'(line_q.size()), 0);
`ifdef STORE_WDATA_PACKER_PERF_CNT_EN
        check("wstall_cnt", wstall_cnt, 64'(stalls));
`endif
        exp_q.delete();
        line_q.delete();
    endtask

    initial begin
        rst_n      = 1'b1;
        cmd_vld    = 1'b0;
        cmd_awlen  = '0;
        cmd_awsize = '0;
        line_vld   = 1'b0;
        line_addr  = '0;
        line_data  = '0;
        axi_wrdy   = 1'b0;
        #1 rst_n   = 1'b0;
        #2;
        check("reset_cmd_rdy",  cmd_rdy,    1);
        check("reset_line_rdy", line_rdy,   0);
        check("reset_wvld",     axi_wvld,   0);
        check("reset_wlast",    axi_wlast,  0);
        check("reset_wdata",    axi_wdata,  0);
        check("reset_done",     burst_done, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_burst(3, 3, 0, 1'b0, 1'b0, 0);  // two full lines, 4 back-to-back beats
        run_burst(2, 2, 0, 1'b1, 1'b0, 0);  // 0x00..0x0F line, one element dropped
        run_burst(1, 3, 2, 1'b0, 1'b0, 0);  // beat 0 stalled 5 cycles
        run_burst(3, 3, 1, 1'b0, 1'b1, 0);  // cmd_vld held through the burst
        run_burst(3, 3, 1, 1'b0, 1'b0, 0);
        run_burst(3, 3, 0, 1'b0, 1'b0, 2);  // reset after 2 of 4 beats
        run_burst(3, 3, 0, 1'b0, 1'b0, 0);
        run_burst(0, 7, 0, 1'b0, 1'b0, 0);  // awsize clamp to 3
        run_burst(255, 0, 0, 1'b0, 1'b0, 0); // 256 beats, no counter wrap

        for (int n = 0; n < 25; n++) begin
            int len, sz;
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 20);
            sz  = $urandom_range(0, 7);
            run_burst(len, sz, 1, 1'b0, 1'b0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
